// File: rtl/rtype_controller_pkg.sv
// Shared constants for the R-type controller: opcode, funct7 values, ALU select codes and FSM states.
// The datapath ALU decodes the same ALU_* codes.
package rtype_controller_pkg;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0000;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_DECODE    = 2'd1;
  localparam state_t ST_EXECUTE   = 2'd2;
  localparam state_t ST_WRITEBACK = 2'd3;

endpackage

// File: rtl/rtype_decoder.sv
// Combinational R-type decoder: {opcode, funct3, funct7} -> ALU select plus illegal flag.
module rtype_decoder
  import rtype_controller_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  output logic [3:0] o_alu_control,
  output logic       o_illegal_op
);

  always_comb begin
    o_alu_control = ALU_ADD;
    o_illegal_op  = 1'b0;
    case ({i_funct7, i_funct3})
      {F7_BASE, 3'b000}: o_alu_control = ALU_ADD;
      {F7_ALT,  3'b000}: o_alu_control = ALU_SUB;
      {F7_BASE, 3'b001}: o_alu_control = ALU_SLL;
      {F7_BASE, 3'b010}: o_alu_control = ALU_SLT;
      {F7_BASE, 3'b011}: o_alu_control = ALU_SLTU;
      {F7_BASE, 3'b100}: o_alu_control = ALU_XOR;
      {F7_BASE, 3'b101}: o_alu_control = ALU_SRL;
      {F7_ALT,  3'b101}: o_alu_control = ALU_SRA;
      {F7_BASE, 3'b110}: o_alu_control = ALU_OR;
      {F7_BASE, 3'b111}: o_alu_control = ALU_AND;
      default:           o_illegal_op  = 1'b1;
    endcase
    if (i_opcode != OP_RTYPE) begin
      o_illegal_op = 1'b1;
    end
  end

endmodule

// File: rtl/rtype_controller.sv
// Single-issue R-type controller: IDLE -> DECODE -> EXECUTE -> WRITEBACK, one instruction per
// four cycles. Outputs are registered; instr_ready is a direct decode of the state register.
module rtype_controller
  import rtype_controller_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_instr_valid,
  input  logic [31:0]      i_instr,
  output logic             o_instr_ready,
  input  logic             i_zero_flag,
  output logic [4:0]       o_rs1,
  output logic [4:0]       o_rs2,
  output logic [4:0]       o_rd,
  output logic [3:0]       o_alu_control,
  output logic             o_regwrite,
  output logic             o_zero_q,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_retired
);

  state_t            r_state;
  logic [31:0]       r_instr;
  logic [4:0]        r_rs1;
  logic [4:0]        r_rs2;
  logic [4:0]        r_rd;
  logic [3:0]        r_alu_control;
  logic              r_regwrite;
  logic              r_zero_q;
  logic              r_illegal;
  logic [CNT_W-1:0]  r_retired;

  logic              w_instr_ready;
  logic              w_handshake;
  logic [3:0]        w_alu_control;
  logic              w_illegal_op;

  assign w_instr_ready = (r_state == ST_IDLE);
  assign w_handshake   = i_instr_valid && w_instr_ready;

  rtype_decoder u_decoder (
    .i_opcode      (r_instr[6:0]),
    .i_funct3      (r_instr[14:12]),
    .i_funct7      (r_instr[31:25]),
    .o_alu_control (w_alu_control),
    .o_illegal_op  (w_illegal_op)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_instr       <= 32'd0;
      r_rs1         <= 5'd0;
      r_rs2         <= 5'd0;
      r_rd          <= 5'd0;
      r_alu_control <= ALU_ADD;
      r_regwrite    <= 1'b0;
      r_zero_q      <= 1'b0;
      r_illegal     <= 1'b0;
      r_retired     <= '0;
    end else begin
      // Pulse outputs default low; only the states below raise them for one cycle.
      r_regwrite <= 1'b0;
      r_illegal  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_handshake) begin
            r_instr <= i_instr;
            r_state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (w_illegal_op) begin
            r_illegal <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_rs1         <= r_instr[19:15];
            r_rs2         <= r_instr[24:20];
            r_rd          <= r_instr[11:7];
            r_alu_control <= w_alu_control;
            r_state       <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          r_state <= ST_WRITEBACK;
        end
        ST_WRITEBACK: begin
          // Writes to x0 still count as retired but never assert the write enable.
          r_regwrite <= (r_rd != 5'd0);
          r_zero_q   <= i_zero_flag;
          r_retired  <= r_retired + CNT_W'(1);
          r_state    <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_instr_ready = w_instr_ready;
  assign o_rs1         = r_rs1;
  assign o_rs2         = r_rs2;
  assign o_rd          = r_rd;
  assign o_alu_control = r_alu_control;
  assign o_regwrite    = r_regwrite;
  assign o_zero_q      = r_zero_q;
  assign o_illegal     = r_illegal;
  assign o_retired     = r_retired;

endmodule
